framebuffer_sink: RTL

//   Responder end of the pixel-plot interface driven by the fill and shape drawers.

---
 rtl/framebuffer_sink.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/framebuffer_sink.sv
// framebuffer_sink: 3-bit on-chip frame buffer with a plot write port, a
// hardware clear engine sharing that write port, and an independent raster
// scanner that streams the stored pixels to the display back-end.
module framebuffer_sink #(
    parameter int WIDTH   = 160,
    parameter int HEIGHT  = 120,
    parameter int H_TOTAL = 200,
    parameter int V_TOTAL = 132,
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] vga_x,
    input  logic [6:0] vga_y,
    input  logic [2:0] vga_colour,
    input  logic       vga_plot,
    output logic       plot_ready,
    input  logic       clear,
    input  logic [2:0] clear_colour,
    output logic       clear_busy,
    output logic [7:0] drop_count,
    output logic [7:0] scan_x,
    output logic [6:0] scan_y,
    output logic [2:0] pix_colour,
    output logic       pix_valid,
    output logic       line_start,
    output logic       frame_start
);

    localparam int DEPTH = WIDTH * HEIGHT;
    localparam int MW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HW    = $clog2(H_TOTAL);
    localparam int VW    = $clog2(V_TOTAL);
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Linear buffer address. The default 160-pixel line is built from shifts
    // so no multiplier is needed; other widths fall back to a multiply.
    function automatic logic [14:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
        logic [14:0] yy;
        yy = {8'd0, y};
        if (WIDTH == 160)
            pix_addr = (yy << 7) + (yy << 5) + {7'd0, x};
        else
            pix_addr = 15'(int'(y) * WIDTH + int'(x));
    endfunction

    // ------------------------------------------------------------------
    // Clear engine
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        C_IDLE     = 1'b0,
        C_CLEARING = 1'b1
    } clr_state_t;

    clr_state_t  state_reg, state_next;
    logic [14:0] clr_addr_reg, clr_addr_next;
    logic [2:0]  clr_colour_reg, clr_colour_next;

    // Clear FSM state, sweep address and latched colour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= C_IDLE;
            clr_addr_reg   <= '0;
            clr_colour_reg <= '0;
        end else begin
            state_reg      <= state_next;
            clr_addr_reg   <= clr_addr_next;
            clr_colour_reg <= clr_colour_next;
        end
    end

    // Next-state logic: a clear request is only looked at while idle; the
    // sweep ends on the write of the last buffer address.
    always_comb begin
        state_next      = state_reg;
        clr_addr_next   = clr_addr_reg;
        clr_colour_next = clr_colour_reg;
        case (state_reg)
            C_IDLE: begin
                if (clear) begin
                    state_next      = C_CLEARING;
                    clr_addr_next   = '0;
                    clr_colour_next = clear_colour;
                end
            end
            C_CLEARING: begin
                if (clr_addr_reg == 15'(DEPTH - 1)) begin
                    state_next    = C_IDLE;
                    clr_addr_next = '0;
                end else begin
                    clr_addr_next = clr_addr_reg + 15'd1;
                end
            end
            default: state_next = C_IDLE;
        endcase
    end

    assign clear_busy = (state_reg == C_CLEARING);
    assign plot_ready = ~clear_busy;

    // ------------------------------------------------------------------
    // Plot path and shared write port
    // ------------------------------------------------------------------
    logic        plot_in_range;
    logic        plot_accept;
    logic        plot_drop;
    logic        wr_en_next;
    logic [14:0] wr_addr_next;
    logic [2:0]  wr_data_next;
    logic        wr_en_reg;
    logic [14:0] wr_addr_reg;
    logic [2:0]  wr_data_reg;
    logic [7:0]  drop_count_reg;

    assign plot_in_range = (int'(vga_x) < WIDTH) && (int'(vga_y) < HEIGHT);
    assign plot_accept   = vga_plot & plot_ready & plot_in_range;
    assign plot_drop     = vga_plot & ~(plot_ready & plot_in_range);

    // Write-port arbitration: the clear sweep owns the port while it runs.
    always_comb begin
        wr_en_next   = plot_accept;
        wr_addr_next = pix_addr(vga_x, vga_y);
        wr_data_next = vga_colour;
        if (state_reg == C_CLEARING) begin
            wr_en_next   = 1'b1;
            wr_addr_next = clr_addr_reg;
            wr_data_next = clr_colour_reg;
        end
    end

    // Register the chosen write request and count rejected plots (saturating).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_reg      <= 1'b0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= '0;
            drop_count_reg <= '0;
        end else begin
            wr_en_reg   <= wr_en_next;
            wr_addr_reg <= wr_addr_next;
            wr_data_reg <= wr_data_next;
            if (plot_drop && (drop_count_reg != 8'hFF))
                drop_count_reg <= drop_count_reg + 8'd1;
        end
    end

    assign drop_count = drop_count_reg;

    // ------------------------------------------------------------------
    // Frame buffer: one write port, one synchronous read port
    // ------------------------------------------------------------------
    logic [2:0]  mem [0:DEPTH-1];
    logic [14:0] rd_addr;
    logic [2:0]  rd_data_reg;

    // Buffer storage; contents survive reset. A same-address read and write
    // in one cycle returns the previous contents.
    always_ff @(posedge clk) begin
        if (wr_en_reg)
            mem[wr_addr_reg[MW-1:0]] <= wr_data_reg;
        rd_data_reg <= mem[rd_addr[MW-1:0]];
    end

    // ------------------------------------------------------------------
    // Raster scanner
    // ------------------------------------------------------------------
    logic [DW-1:0] div_reg;
    logic [HW-1:0] h_reg;
    logic [VW-1:0] v_reg;
    logic          tick;
    logic          active;
    logic [7:0]    x_cur;
    logic [6:0]    y_cur;

    assign tick   = (div_reg == '0);
    assign active = (int'(h_reg) < WIDTH) && (int'(v_reg) < HEIGHT);
    assign x_cur  = 8'(h_reg);
    assign y_cur  = 7'(v_reg);
    assign rd_addr = active ? pix_addr(x_cur, y_cur) : 15'd0;

    // Tick divider plus horizontal/vertical position counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg <= '0;
            h_reg   <= '0;
            v_reg   <= '0;
        end else begin
            if (div_reg == DW'(CLK_DIV - 1))
                div_reg <= '0;
            else
                div_reg <= div_reg + DW'(1);
            if (tick) begin
                if (h_reg == HW'(H_TOTAL - 1)) begin
                    h_reg <= '0;
                    if (v_reg == VW'(V_TOTAL - 1))
                        v_reg <= '0;
                    else
                        v_reg <= v_reg + VW'(1);
                end else begin
                    h_reg <= h_reg + HW'(1);
                end
            end
        end
    end

    logic       s1_valid;
    logic [7:0] s1_x;
    logic [6:0] s1_y;

    // Stage 1: carry the selected position alongside the buffer read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
        end else begin
            s1_valid <= tick & active;
            s1_x     <= x_cur;
            s1_y     <= y_cur;
        end
    end

    // Stage 2: registered pixel outputs; position holds between active ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_valid   <= 1'b0;
            pix_colour  <= '0;
            scan_x      <= '0;
            scan_y      <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_valid   <= s1_valid;
            pix_colour  <= s1_valid ? rd_data_reg : 3'd0;
            line_start  <= s1_valid && (s1_x == 8'd0);
            frame_start <= s1_valid && (s1_x == 8'd0) && (s1_y == 7'd0);
            if (s1_valid) begin
                scan_x <= s1_x;
                scan_y <= s1_y;
            end
        end
    end

endmodule
